// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the requesters and the arbiter. It also carries the
// registered outputs that drive reg_file.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] writereg;
  logic [DATA_W-1:0] writedata;
  logic              writeenable;
  logic              wr_src;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, clr_start,
    input  a_ready, b_ready, clr_busy, clr_done, writereg, writedata, writeenable, wr_src
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, clr_start,
    output a_ready, b_ready, clr_busy, clr_done, writereg, writedata, writeenable, wr_src
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single reg_file write port. A built-in sequencer
// zeroes every register on command.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_REGS = 8
) (
  input logic                     clk,
  input logic                     reset,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StArb, StClear} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;   // 1: B was granted last
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              src_q, src_d;
  logic              done_q, done_d;
  logic              a_ready, b_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    src_d   = src_q;
    done_d  = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      StArb: begin
        // Clear has priority: no grant on the edge that starts it.
        if (!reset && !bus.clr_start) begin
          a_ready = bus.a_valid && (!bus.b_valid || last_q);
          b_ready = bus.b_valid && (!bus.a_valid || !last_q);
        end
        if (bus.clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (a_ready) begin
          we_d    = 1'b1;
          wreg_d  = bus.a_reg;
          wdata_d = bus.a_data;
          src_d   = 1'b0;
          last_d  = 1'b0;
        end else if (b_ready) begin
          we_d    = 1'b1;
          wreg_d  = bus.b_reg;
          wdata_d = bus.b_data;
          src_d   = 1'b1;
          last_d  = 1'b1;
        end
      end
      StClear: begin
        we_d    = 1'b1;
        wreg_d  = cnt_q;
        wdata_d = '0;
        src_d   = 1'b0;
        if (cnt_q == LastIdx) begin
          state_d = StArb;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StArb;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      src_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
      done_q  <= done_d;
    end
  end

  assign bus.a_ready     = a_ready;
  assign bus.b_ready     = b_ready;
  assign bus.clr_busy    = (state_q == StClear);
  assign bus.clr_done    = done_q;
  assign bus.writereg    = wreg_q;
  assign bus.writedata   = wdata_q;
  assign bus.writeenable = we_q;
  assign bus.wr_src      = src_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed table, clear/reset sequences and a
// randomized run against a queue-based reference model.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in for reg_file: commits on the edge after a write is presented.
  logic [7:0] rf [8];
  always @(posedge clk) if (bus.writeenable) rf[bus.writereg] <= bus.writedata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [2:0] ar, input logic [7:0] ad,
                       input logic bv, input logic [2:0] br, input logic [7:0] bd,
                       input logic cs);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
    bus.clr_start = cs;
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [2:0] rg,
                         input logic [7:0] d, input logic s);
    chk({tag, ".we"}, bus.writeenable, we);
    chk({tag, ".reg"}, bus.writereg, rg);
    chk({tag, ".data"}, bus.writedata, d);
    chk({tag, ".src"}, bus.wr_src, s);
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'(i + 1), 1'b0, 3'd0, 8'd0, 1'b0);
      #2 chk("preload.a_ready", bus.a_ready, 1'b1);
      tick();
    end
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
    tick();
  endtask

  typedef struct {
    logic av; logic [2:0] ar; logic [7:0] ad;
    logic bv; logic [2:0] br; logic [7:0] bd;
    logic ear; logic ebr;
    logic ewe; logic [2:0] ereg; logic [7:0] edata; logic esrc;
  } vec_t;
  vec_t vecs[11];

  // Reference model state: pending clear writes are a queue of register indices.
  logic       m_last;
  logic [2:0] m_clrq[$];
  logic       m_we, m_src, m_done;
  logic [2:0] m_reg;
  logic [7:0] m_data;
  logic [7:0] m_rf [8];
  logic       pa, pb;
  logic [2:0] par, pbr;
  logic [7:0] pad, pbd;

  task automatic model_reset();
    m_last = 1'b1; m_clrq = {}; m_we = 1'b0; m_src = 1'b0; m_done = 1'b0;
    m_reg = '0; m_data = '0;
  endtask

  task automatic rand_cycle(input bit quiet);
    logic r, cs, ea, eb, idle;
    r  = !quiet && ($urandom_range(99) == 0);
    cs = !quiet && ($urandom_range(29) == 0);
    if (!quiet && !pa && $urandom_range(4) < 3) begin
      pa = 1'b1; par = 3'($urandom); pad = 8'($urandom);
    end
    if (!quiet && !pb && $urandom_range(4) < 3) begin
      pb = 1'b1; pbr = 3'($urandom); pbd = 8'($urandom);
    end
    reset = r;
    drive(pa, par, pad, pb, pbr, pbd, cs);
    #2;
    idle = !r && !cs && (m_clrq.size() == 0);
    ea = idle && pa && (!pb || m_last);
    eb = idle && pb && (!pa || !m_last);
    chk("rand.a_ready", bus.a_ready, ea);
    chk("rand.b_ready", bus.b_ready, eb);
    chk("rand.busy", bus.clr_busy, m_clrq.size() != 0);
    chk("rand.done", bus.clr_done, m_done);
    tick();
    if (m_we) m_rf[m_reg] = m_data;
    if (r) begin
      model_reset();
    end else if (m_clrq.size() != 0) begin
      m_reg = m_clrq.pop_front(); m_we = 1'b1; m_data = '0; m_src = 1'b0;
      m_done = (m_clrq.size() == 0);
    end else begin
      m_done = 1'b0;
      m_we = 1'b0;
      if (cs) begin
        for (int i = 0; i < 8; i++) m_clrq.push_back(3'(i));
      end else if (ea) begin
        m_we = 1'b1; m_reg = par; m_data = pad; m_src = 1'b0; m_last = 1'b0; pa = 1'b0;
      end else if (eb) begin
        m_we = 1'b1; m_reg = pbr; m_data = pbd; m_src = 1'b1; m_last = 1'b1; pb = 1'b0;
      end
    end
    chk_out("rand", m_we, m_reg, m_data, m_src);
  endtask

  initial begin
    //              av ar  ad     bv br  bd     ear  ebr  we  reg data   src
    vecs[0]  = '{1, 3'd3, 8'd15, 1, 3'd4, 8'd27, 1, 0, 1, 3'd3, 8'd15, 0};
    vecs[1]  = '{1, 3'd5, 8'd33, 1, 3'd4, 8'd27, 0, 1, 1, 3'd4, 8'd27, 1};
    vecs[2]  = '{1, 3'd5, 8'd33, 0, 3'd0, 8'd0,  1, 0, 1, 3'd5, 8'd33, 0};
    vecs[3]  = '{0, 3'd0, 8'd0,  0, 3'd0, 8'd0,  0, 0, 0, 3'd5, 8'd33, 0};
    vecs[4]  = '{0, 3'd0, 8'd0,  1, 3'd6, 8'h44, 0, 1, 1, 3'd6, 8'h44, 1};
    vecs[5]  = '{1, 3'd0, 8'd5,  0, 3'd0, 8'd0,  1, 0, 1, 3'd0, 8'd5,  0};
    vecs[6]  = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 1, 1, 3'd2, 8'h22, 1};
    vecs[7]  = '{1, 3'd1, 8'h11, 1, 3'd7, 8'h77, 1, 0, 1, 3'd1, 8'h11, 0};
    vecs[8]  = '{1, 3'd3, 8'haa, 1, 3'd7, 8'h77, 0, 1, 1, 3'd7, 8'h77, 1};
    vecs[9]  = '{1, 3'd3, 8'haa, 0, 3'd0, 8'd0,  1, 0, 1, 3'd3, 8'haa, 0};
    vecs[10] = '{0, 3'd0, 8'd0,  0, 3'd0, 8'd0,  0, 0, 0, 3'd3, 8'haa, 0};

    // Reset: readies held low even with both requesters valid.
    reset = 1'b1;
    drive(1'b1, 3'd1, 8'd1, 1'b1, 3'd2, 8'd2, 1'b0);
    tick();
    #2;
    chk("reset.a_ready", bus.a_ready, 1'b0);
    chk("reset.b_ready", bus.b_ready, 1'b0);
    tick();
    chk_out("reset", 1'b0, 3'd0, 8'd0, 1'b0);
    chk("reset.busy", bus.clr_busy, 1'b0);
    chk("reset.done", bus.clr_done, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd, 1'b0);
      #2;
      chk($sformatf("vec%0d.a_ready", i), bus.a_ready, vecs[i].ear);
      chk($sformatf("vec%0d.b_ready", i), bus.b_ready, vecs[i].ebr);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].ewe, vecs[i].ereg, vecs[i].edata, vecs[i].esrc);
    end

    // Fairness: A granted last, so a continuous tie alternates B,A,B,A,B,A.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'(k), 8'(k), 1'b1, 3'(7 - k), 8'(8'h80 + k), 1'b0);
      #2;
      chk("fair.a_ready", bus.a_ready, (k % 2) == 1);
      chk("fair.b_ready", bus.b_ready, (k % 2) == 0);
      chk("fair.not_both", bus.a_ready && bus.b_ready, 1'b0);
      tick();
      chk("fair.src", bus.wr_src, (k % 2) == 0);
    end

    // Clear with A valid on the start cycle; CLR_START held into CLEAR is ignored.
    preload();
    drive(1'b1, 3'd2, 8'd9, 1'b0, 3'd0, 8'd0, 1'b1);
    #2 chk("clr.start_a_ready", bus.a_ready, 1'b0);
    tick();
    chk("clr.start_busy", bus.clr_busy, 1'b1);
    chk("clr.start_we", bus.writeenable, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.clr_start = (i < 2);
      #2 chk("clr.a_ready", bus.a_ready, 1'b0);
      tick();
      chk_out($sformatf("clr%0d", i), 1'b1, 3'(i), 8'd0, 1'b0);
      chk("clr.busy", bus.clr_busy, i < 7);
      chk("clr.done", bus.clr_done, i == 7);
    end
    #2 chk("clr.after_a_ready", bus.a_ready, 1'b1);
    tick();
    chk_out("clr.after", 1'b1, 3'd2, 8'd9, 1'b0);
    chk("clr.done_fall", bus.clr_done, 1'b0);
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) chk($sformatf("clr.rf%0d", i), rf[i], (i == 2) ? 8'd9 : 8'd0);

    // Reset on the third clear cycle aborts the walk after REG2.
    preload();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    repeat (3) tick();
    chk("rstclr.reg2", bus.writereg, 3'd2);
    reset = 1'b1;
    tick();
    chk_out("rstclr", 1'b0, 3'd0, 8'd0, 1'b0);
    chk("rstclr.busy", bus.clr_busy, 1'b0);
    chk("rstclr.done", bus.clr_done, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rstclr.no_done", bus.clr_done, 1'b0);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("rstclr.rf%0d", i), rf[i], (i < 3) ? 8'd0 : 8'(i + 1));

    // Randomized run against the reference model.
    reset = 1'b1;
    drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = rf[i];
    pa = 1'b0; pb = 1'b0; par = '0; pbr = '0; pad = '0; pbd = '0;
    for (int i = 0; i < 600; i++) rand_cycle(1'b0);
    for (int i = 0; i < 20; i++) rand_cycle(1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("rand.rf%0d", i), rf[i], m_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
